// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Karatsuba multipliers.
package mul_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ACC, OUT} kara_state_e;

  localparam int KARA_CNT_W = 8;

  function automatic int kara_latency(input int sub_lat);
    return sub_lat + 5;
  endfunction
endpackage

// File: rtl/addcpred.sv
// Plain carry-propagate adder with carry in/out; used as a subtractor via a + ~b + 1.
module addcpred #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/kara_precomp.sv
// Karatsuba operand split with sign and absolute differences |x1-x0|, |y0-y1|.
module kara_precomp #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH/2-1:0] x0,
  output logic [WIDTH/2-1:0] x1,
  output logic [WIDTH/2-1:0] y0,
  output logic [WIDTH/2-1:0] y1,
  output logic [WIDTH/2-1:0] da,
  output logic [WIDTH/2-1:0] db,
  output logic               sign
);
  localparam int WH = WIDTH/2;

  logic [WH-1:0] dx_f, dx_r, dy_f, dy_r;
  logic          cx_f, cx_r, cy_f, cy_r;
  logic          unused_cout;

  assign {x1, x0} = a;
  assign {y1, y0} = b;

  // Both directions are computed so the magnitude is a mux, not a negate after the compare.
  addcpred #(.W(WH)) u_dx_f (.a(x1), .b(~x0), .cin(1'b1), .sum(dx_f), .cout(cx_f));
  addcpred #(.W(WH)) u_dx_r (.a(x0), .b(~x1), .cin(1'b1), .sum(dx_r), .cout(cx_r));
  addcpred #(.W(WH)) u_dy_f (.a(y0), .b(~y1), .cin(1'b1), .sum(dy_f), .cout(cy_f));
  addcpred #(.W(WH)) u_dy_r (.a(y1), .b(~y0), .cin(1'b1), .sum(dy_r), .cout(cy_r));

  assign unused_cout = cx_r ^ cy_r;
  assign da   = cx_f ? dx_f : dx_r;
  assign db   = cy_f ? dy_f : dy_r;
  assign sign = (~cx_f) ^ (~cy_f);
endmodule

// File: rtl/mul32_80.sv
// Pipelined unsigned half-width multiplier; product appears LAT edges after the operands.
module mul32_80 #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  localparam int PW = 2*WIDTH;

  logic [PW-1:0] pipe [LAT];

  always_ff @(posedge clk) begin
    pipe[0] <= PW'(a) * PW'(b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign p = pipe[LAT-1];
endmodule

// File: rtl/mul_kara_seq.sv
// Resource-shared Karatsuba multiplier: one half-width multiplier issued z0, z2, m in turn.
module mul_kara_seq
  import mul_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SUB_LAT = 2,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_c,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  // state | meaning
  // IDLE  | waiting for operands
  // ISSUE | feeding (x0,y0), (x1,y1), (da,db) to the shared multiplier
  // DRAIN | waiting for the last products to emerge
  // ACC   | recombining z0, z2, m into the full product
  // OUT   | result held until out_ready
  localparam int WH  = WIDTH/2;
  localparam int W2  = 2*WIDTH;
  localparam int LAT = kara_latency(SUB_LAT);
  localparam logic [KARA_CNT_W-1:0] ISS_Z0 = KARA_CNT_W'(0);
  localparam logic [KARA_CNT_W-1:0] ISS_Z2 = KARA_CNT_W'(1);
  localparam logic [KARA_CNT_W-1:0] ISS_M  = KARA_CNT_W'(2);
  localparam logic [KARA_CNT_W-1:0] CAP_Z0 = KARA_CNT_W'(LAT-4);
  localparam logic [KARA_CNT_W-1:0] CAP_Z2 = KARA_CNT_W'(LAT-3);
  localparam logic [KARA_CNT_W-1:0] CAP_M  = KARA_CNT_W'(LAT-2);

  kara_state_e           state, state_nxt;
  logic [KARA_CNT_W-1:0] cyc;
  logic                  accept;
  logic [WH-1:0]         pre_x0, pre_x1, pre_y0, pre_y1, pre_da, pre_db;
  logic                  pre_sign;
  logic [WH-1:0]         x0_q, x1_q, y0_q, y1_q, da_q, db_q, mul_a, mul_b;
  logic                  sign_q;
  logic [TAG_W-1:0]      tag_q;
  logic [WIDTH-1:0]      mul_p, z0, z2, m;
  logic [W2-1:0]         t_a, t_b, t_c, cs_s, cs_c, acc_c;

  kara_precomp #(.WIDTH(WIDTH)) u_precomp (
    .a(in_a), .b(in_b), .x0(pre_x0), .x1(pre_x1), .y0(pre_y0), .y1(pre_y1),
    .da(pre_da), .db(pre_db), .sign(pre_sign)
  );

  mul32_80 #(.WIDTH(WH), .LAT(SUB_LAT)) u_mul (.clk(clk), .a(mul_a), .b(mul_b), .p(mul_p));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: if (cyc == ISS_M) state_nxt = DRAIN;
      DRAIN: if (cyc == CAP_M) state_nxt = ACC;
      ACC:   state_nxt = OUT;
      OUT: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign accept = in_valid & in_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cyc <= '0;
      else if (state == ISSUE || state == DRAIN || state == ACC) cyc <= cyc + 1'b1;
      if (state == ACC) begin
        out_valid <= 1'b1;
        out_c     <= acc_c;
        out_tag   <= tag_q;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Capture slots are fixed offsets of the issue counter; the multiplier carries no valid bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      {x1_q, x0_q} <= {pre_x1, pre_x0};
      {y1_q, y0_q} <= {pre_y1, pre_y0};
      {da_q, db_q} <= {pre_da, pre_db};
      sign_q       <= pre_sign;
      tag_q        <= in_tag;
    end
    if (state == ISSUE) begin
      case (cyc)
        ISS_Z0:  begin mul_a <= x0_q; mul_b <= y0_q; end
        ISS_Z2:  begin mul_a <= x1_q; mul_b <= y1_q; end
        default: begin mul_a <= da_q; mul_b <= db_q; end
      endcase
    end
    if (state == ISSUE || state == DRAIN) begin
      if (cyc == CAP_Z0) z0 <= mul_p;
      if (cyc == CAP_Z2) z2 <= mul_p;
      if (cyc == CAP_M)  m  <= mul_p;
    end
  end

  // Subtracting m is done modulo 2^W2; the true middle term is never negative.
  assign t_a   = {z2, z0};
  assign t_b   = (W2'(z2) + W2'(z0)) << WH;
  assign t_c   = (sign_q ? (~W2'(m) + 1'b1) : W2'(m)) << WH;
  assign cs_s  = t_a ^ t_b ^ t_c;
  assign cs_c  = ((t_a & t_b) | (t_a & t_c) | (t_b & t_c)) << 1;
  assign acc_c = cs_s + cs_c;
endmodule

// File: tb/tb_mul_kara_seq.sv
// Bench for mul_kara_seq: directed products plus randomized traffic on two widths.
module tb_mul_kara_seq;
  localparam int W0 = 64, SL0 = 2, W1 = 160, SL1 = 3, TW = 4;
  localparam int PW0 = 2*W0, PW1 = 2*W1, CW = 2*W1;
  localparam int N0 = 1000, N1 = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst0, in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [W0-1:0]   in_a0, in_b0;
  logic [TW-1:0]   in_tag0, out_tag0;
  logic [PW0-1:0]  out_c0;
  logic            rst1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [W1-1:0]   in_a1, in_b1;
  logic [TW-1:0]   in_tag1, out_tag1;
  logic [PW1-1:0]  out_c1;

  mul_kara_seq #(.WIDTH(W0), .SUB_LAT(SL0), .TAG_W(TW)) u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0),
    .in_b(in_b0), .in_tag(in_tag0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_c(out_c0), .out_tag(out_tag0), .busy(busy0));

  mul_kara_seq #(.WIDTH(W1), .SUB_LAT(SL1), .TAG_W(TW)) u_dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1),
    .in_b(in_b1), .in_tag(in_tag1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_c(out_c1), .out_tag(out_tag1), .busy(busy1));

  int   checks = 0, errors = 0, edge_n = 0;
  logic mon_en = 1'b0;
  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one operation in flight; its result is due a fixed latency after acceptance.
  logic           p0 = 1'b0, p1 = 1'b0;
  int             due0 = 0, due1 = 0, acc0 = 0, acc1 = 0, done0 = 0, done1 = 0;
  logic [PW0-1:0] ec0;
  logic [PW1-1:0] ec1;
  logic [TW-1:0]  et0, et1;

  always @(negedge clk) if (mon_en) begin : mon0
    logic ev, er;
    ev = p0 && (edge_n >= due0);
    er = !rst0 && (!p0 || (ev && out_ready0));
    chk1("out_valid0", out_valid0, ev);
    chk1("in_ready0", in_ready0, er);
    chk1("busy0", busy0, p0);
    if (ev) begin
      chk("out_c0", CW'(out_c0), CW'(ec0));
      chk("out_tag0", CW'(out_tag0), CW'(et0));
    end
    if (rst0) p0 = 1'b0;
    else begin
      if (ev && out_ready0) begin p0 = 1'b0; done0++; end
      if (in_valid0 && er) begin
        p0 = 1'b1; due0 = edge_n + 1 + SL0 + 5;
        ec0 = PW0'(in_a0) * PW0'(in_b0); et0 = in_tag0; acc0++;
      end
    end
  end

  always @(negedge clk) if (mon_en) begin : mon1
    logic ev, er;
    ev = p1 && (edge_n >= due1);
    er = !rst1 && (!p1 || (ev && out_ready1));
    chk1("out_valid1", out_valid1, ev);
    chk1("in_ready1", in_ready1, er);
    chk1("busy1", busy1, p1);
    if (ev) begin
      chk("out_c1", CW'(out_c1), CW'(ec1));
      chk("out_tag1", CW'(out_tag1), CW'(et1));
    end
    if (rst1) p1 = 1'b0;
    else begin
      if (ev && out_ready1) begin p1 = 1'b0; done1++; end
      if (in_valid1 && er) begin
        p1 = 1'b1; due1 = edge_n + 1 + SL1 + 5;
        ec1 = PW1'(in_a1) * PW1'(in_b1); et1 = in_tag1; acc1++;
      end
    end
  end

  function automatic logic [W0-1:0] rnd0();
    logic [W0/2-1:0] h;
    h = $urandom();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {h, h};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  function automatic logic [W1-1:0] rnd1();
    logic [W1/2-1:0] h;
    h = (W1/2)'({$urandom(), $urandom(), $urandom()});
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {h, h};
      default: return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endcase
  endfunction

  task automatic wait_out0(input string nm, input int lat);
    int n = 0;
    while (!out_valid0 && n < 40) begin tick(); n++; end
    chki({nm, "_lat"}, n, lat);
  endtask

  task automatic run0(input logic [W0-1:0] a, input logic [W0-1:0] b, input logic [TW-1:0] tag,
                      input logic [PW0-1:0] exp, input string nm);
    chk1({nm, "_rdy"}, in_ready0, 1'b1);
    in_a0 = a; in_b0 = b; in_tag0 = tag; in_valid0 = 1'b1; out_ready0 = 1'b1;
    tick();
    in_valid0 = 1'b0; in_a0 = rnd0(); in_b0 = rnd0(); in_tag0 = ~tag;
    wait_out0(nm, 7);
    chk(nm, CW'(out_c0), CW'(exp));
    chk({nm, "_tag"}, CW'(out_tag0), CW'(tag));
    tick();
  endtask

  task automatic rand0();
    int cyc = 0;
    int target = acc0 + N0;
    while (acc0 < target && cyc < 25*N0) begin
      in_valid0 = ($urandom_range(0, 3) != 0); in_a0 = rnd0(); in_b0 = rnd0();
      in_tag0 = TW'($urandom()); out_ready0 = ($urandom_range(0, 3) != 0);
      tick(); cyc++;
    end
    chki("rand0_accepts", acc0, target);
    in_valid0 = 1'b0; out_ready0 = 1'b1; cyc = 0;
    while (busy0 && cyc < 100) begin tick(); cyc++; end
    chk1("rand0_drain", busy0, 1'b0);
  endtask

  task automatic rand1();
    int cyc = 0;
    int target = acc1 + N1;
    while (acc1 < target && cyc < 25*N1) begin
      in_valid1 = ($urandom_range(0, 3) != 0); in_a1 = rnd1(); in_b1 = rnd1();
      in_tag1 = TW'($urandom()); out_ready1 = ($urandom_range(0, 3) != 0);
      tick(); cyc++;
    end
    chki("rand1_accepts", acc1, target);
    in_valid1 = 1'b0; out_ready1 = 1'b1; cyc = 0;
    while (busy1 && cyc < 100) begin tick(); cyc++; end
    chk1("rand1_drain", busy1, 1'b0);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; in_tag0 = '0; out_ready0 = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_tag1 = '0; out_ready1 = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    chk1("rst_out_valid0", out_valid0, 1'b0);
    chk("rst_out_c0", CW'(out_c0), '0);
    chk("rst_out_tag0", CW'(out_tag0), '0);
    chk1("rst_busy0", busy0, 1'b0);
    chk1("rst_in_ready0", in_ready0, 1'b0);
    chk("rst_out_c1", CW'(out_c1), '0);
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    run0(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 4'hC,
         128'hFFFFFFFFFFFFFFFE_0000000000000001, "all_ones");
    run0(64'h00000001_00000002, 64'h00000003_00000001, 4'h1,
         128'h0000000000000003_0000000700000002, "pos_sign");
    run0(64'h00000001_00000002, 64'h00000001_00000003, 4'h2,
         128'h0000000000000001_0000000500000006, "neg_sign");
    run0(64'h00000005_00000005, 64'h00000007_00000007, 4'h3,
         128'h0000000000000023_0000004600000023, "eq_halves");
    run0(64'h0, 64'hFFFFFFFF_FFFFFFFF, 4'h4, 128'h0, "zero");

    // backpressure: result held, pending operands refused, then both handshakes together
    in_a0 = 64'h10; in_b0 = 64'h20; in_tag0 = 4'h9; in_valid0 = 1'b1; out_ready0 = 1'b0;
    tick();
    in_valid0 = 1'b0;
    wait_out0("bp", 7);
    in_a0 = 64'h00000001_00000000; in_b0 = 64'h00000001_00000000; in_tag0 = 4'hA; in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_c", CW'(out_c0), CW'(128'h200));
      chk("bp_hold_tag", CW'(out_tag0), CW'(4'h9));
      chk1("bp_in_ready", in_ready0, 1'b0);
      tick();
    end
    out_ready0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    chk1("b2b_valid_drop", out_valid0, 1'b0);
    wait_out0("b2b", 7);
    chk("b2b_c", CW'(out_c0), CW'(128'h1_0000000000000000));
    chk("b2b_tag", CW'(out_tag0), CW'(4'hA));
    tick();

    // reset three edges into an operation discards it
    in_a0 = 64'h7; in_b0 = 64'h9; in_tag0 = 4'h6; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    tick(); tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk1("rst_no_out", out_valid0, 1'b0);
      tick();
    end
    run0(64'h3, 64'h5, 4'h5, 128'hF, "after_rst");

    fork
      rand0();
      rand1();
    join
    chki("ops0_balance", done0 + 1, acc0);
    chki("ops1_balance", done1, acc1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
